ui_draw_arbiter: RTL and testbench

//   Shares the single VGA pixel-write port between N UI drawing units (up/down/left/right arrow units).

---
 rtl/ui_draw_arbiter.sv | 134 +++++++++++++
 tb/tb_ui_draw_arbiter.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ui_draw_arbiter.sv
// rtl/ui_draw_arbiter.sv - round-robin owner of the shared VGA pixel-write port
module ui_draw_arbiter #(
  parameter int N_REQ = 4,
  parameter int TMO_W = 24
) (
  input  logic               clk,
  input  logic               reset_vga,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   done,
  input  logic [8*N_REQ-1:0] x_in,
  input  logic [7*N_REQ-1:0] y_in,
  input  logic [3*N_REQ-1:0] colour_in,
  input  logic [N_REQ-1:0]   we_in,
  output logic [N_REQ-1:0]   unit_start,
  output logic [N_REQ-1:0]   unit_rst_n,
  output logic [N_REQ-1:0]   grant,
  output logic [7:0]         x,
  output logic [6:0]         y,
  output logic [2:0]         colour,
  output logic               writeEn,
  output logic               busy,
  output logic               timeout_err
);

  localparam int PW = (N_REQ > 2) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_DRAW    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    win;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_next;
  logic             tmo_hit;
  logic [PW-1:0]    pick;
  logic             found;
  logic             leave;
  logic             done_w;
  logic             req_w;

  // Rotating priority scan: first requester at or after ptr wins.
  always_comb begin
    int j;
    pick  = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr) + k;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        pick  = PW'(j);
      end
    end
  end

  // End-of-turn conditions for the current owner while drawing; the counter
  // fires on the DRAW cycle whose increment would make it all-ones.
  always_comb begin
    done_w   = done[win];
    req_w    = req[win];
    tmo_next = tmo_cnt + 1'b1;
    tmo_hit  = &tmo_next;
    leave    = done_w | ~req_w | tmo_hit;
  end

  // Arbitration FSM, owner tracking, round-robin pointer and timeout bookkeeping.
  always_ff @(posedge clk or posedge reset_vga) begin
    if (reset_vga) begin
      state       <= S_IDLE;
      ptr         <= '0;
      win         <= '0;
      grant       <= '0;
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            win   <= pick;
            grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: state <= S_DRAW;
        S_DRAW: begin
          tmo_cnt <= tmo_next;
          if (leave) begin
            state <= S_RELEASE;
            // A finishing unit or a voluntary abort wins over a coincident timeout.
            if (!done_w && req_w && tmo_hit) timeout_err <= 1'b1;
          end
        end
        default: begin
          ptr     <= (win == PW'(N_REQ-1)) ? '0 : win + PW'(1);
          grant   <= '0;
          tmo_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  // Pixel path: only the owner's pixels captured in a DRAW cycle that stays in DRAW reach the adapter.
  always_ff @(posedge clk or posedge reset_vga) begin
    if (reset_vga) begin
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end else if (state == S_DRAW && !leave) begin
      x       <= x_in[8*win +: 8];
      y       <= y_in[7*win +: 7];
      colour  <= colour_in[3*win +: 3];
      writeEn <= we_in[win];
    end else begin
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      writeEn <= 1'b0;
    end
  end

  // Unit controls derive from the registered grant so reset clears them without a clock edge.
  always_comb begin
    unit_start = (state == S_LAUNCH) ? grant : '0;
    unit_rst_n = (state == S_LAUNCH || state == S_DRAW) ? grant : '0;
    busy       = (state != S_IDLE);
  end

endmodule

// File: tb/tb_ui_draw_arbiter.sv
// tb/tb_ui_draw_arbiter.sv - randomized bench for ui_draw_arbiter against a turn-based model
module tb_ui_draw_arbiter;

  localparam int N    = 4;
  localparam int TW   = 4;
  localparam int MAXD = (1 << TW) - 1;

  logic           clk = 1'b0;
  logic           reset_vga;
  logic [N-1:0]   req, done, we_in;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] colour_in;
  logic [N-1:0]   unit_start, unit_rst_n, grant;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic           writeEn, busy, timeout_err;

  ui_draw_arbiter #(.N_REQ(N), .TMO_W(TW)) dut (
    .clk(clk), .reset_vga(reset_vga), .req(req), .done(done),
    .x_in(x_in), .y_in(y_in), .colour_in(colour_in), .we_in(we_in),
    .unit_start(unit_start), .unit_rst_n(unit_rst_n), .grant(grant),
    .x(x), .y(y), .colour(colour), .writeEn(writeEn),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: owner (-1 = nobody), turn age (0 = start cycle, k = k-th drawing cycle),
  // rel = owner's turn is in its closing cycle, ptr = next unit to get priority.
  int         own, age, ptr;
  bit         rel, terr;
  logic [7:0] ex;
  logic [6:0] ey;
  logic [2:0] ec;
  logic       ew;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    own = -1; age = 0; ptr = 0; rel = 0; terr = 0;
    ex = '0; ey = '0; ec = '0; ew = 1'b0;
  endtask

  task automatic check_outputs();
    logic [N-1:0] g, s, r;
    g = '0; s = '0; r = '0;
    if (own >= 0) begin
      g[own] = 1'b1;
      if (!rel) r[own] = 1'b1;
      if (!rel && age == 0) s[own] = 1'b1;
    end
    check("grant", grant, g);
    check("unit_start", unit_start, s);
    check("unit_rst_n", unit_rst_n, r);
    check("busy", busy, (own >= 0));
    check("x", x, ex);
    check("y", y, ey);
    check("colour", colour, ec);
    check("writeEn", writeEn, ew);
    check("timeout_err", timeout_err, terr);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit found;
    ex = '0; ey = '0; ec = '0; ew = 1'b0;
    if (own < 0) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && req[(ptr + k) % N]) begin
          found = 1; own = (ptr + k) % N; age = 0;
        end
      end
    end else if (rel) begin
      ptr = (own + 1) % N; own = -1; rel = 0;
    end else if (age == 0) begin
      age = 1;
    end else begin
      if (done[own]) rel = 1;
      else if (!req[own]) rel = 1;
      else if (age == MAXD) begin rel = 1; terr = 1; end
      if (!rel) begin
        ex = x_in[8*own +: 8]; ey = y_in[7*own +: 7];
        ec = colour_in[3*own +: 3]; ew = we_in[own];
        age++;
      end
    end
  endtask

  task automatic rand_inputs();
    x_in = 32'($urandom); y_in = 28'($urandom);
    colour_in = 12'($urandom); we_in = 4'($urandom);
    done = 4'($urandom) & 4'($urandom) & 4'($urandom);
    for (int i = 0; i < N; i++)
      if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
    if (own >= 0) begin
      done[own] = 1'b0;
      if (rel) req[own] = 1'b0;
      else if (age >= 1) begin
        if ($urandom_range(0, 11) == 0) done[own] = 1'b1;
        if ($urandom_range(0, 40) == 0) req[own] = 1'b0;
      end
    end
  endtask

  task automatic clear_inputs();
    req = '0; done = '0; we_in = '0; x_in = '0; y_in = '0; colour_in = '0;
  endtask

  initial begin
    bit hit;
    clear_inputs();
    reset_vga = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    reset_vga = 1'b0;
    model_step();

    // Random traffic with done, aborts, timeouts and stray done pulses.
    repeat (1500) begin
      @(negedge clk);
      check_outputs();
      rand_inputs();
      model_step();
    end

    // Asynchronous reset in the middle of a drawing turn.
    hit = 0;
    for (int c = 0; c < 2000 && !hit; c++) begin
      @(negedge clk);
      check_outputs();
      if (own >= 0 && !rel && age >= 2) hit = 1;
      else begin rand_inputs(); model_step(); end
    end
    check("reach_draw", hit, 1);
    #2 reset_vga = 1'b1;
    #1;
    check("rst_grant", grant, 0);
    check("rst_writeEn", writeEn, 0);
    check("rst_unit_rst_n", unit_rst_n, 0);
    check("rst_unit_start", unit_start, 0);
    check("rst_busy", busy, 0);
    clear_inputs();
    @(negedge clk);
    reset_vga = 1'b0;
    model_reset();
    model_step();

    // Done coinciding with the timeout cycle, stray done on other units.
    repeat (40) begin
      @(negedge clk);
      check_outputs();
      x_in = 32'($urandom); y_in = 28'($urandom);
      colour_in = 12'($urandom); we_in = 4'($urandom);
      req = 4'b0001;
      done = 4'($urandom) & 4'b1110;
      if (own == 0 && !rel && age == MAXD) done[0] = 1'b1;
      model_step();
    end
    check("no_err_on_done_tmo", timeout_err, 0);

    // Unit 0 never finishes: its turn times out.
    repeat (40) begin
      @(negedge clk);
      check_outputs();
      x_in = 32'($urandom); we_in = 4'($urandom);
      req = 4'b0001; done = '0;
      model_step();
    end
    check("tmo_err_set", timeout_err, 1);

    // Error flag must stay set through ordinary later turns.
    repeat (400) begin
      @(negedge clk);
      check_outputs();
      rand_inputs();
      model_step();
    end
    check("tmo_err_sticky", timeout_err, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
